// File: rtl/unstacker_if.sv
// Stream bundle for the unstacker: 128-bit chunk input side and 8-bit pixel output side.
// The unstacker uses the slave modport; the environment driving it uses master.
interface unstacker_if;
    logic         chunk_tvalid;
    logic         chunk_tready;
    logic [127:0] chunk_tdata;
    logic         chunk_tlast;
    logic         pixel_tvalid;
    logic         pixel_tready;
    logic [7:0]   pixel_tdata;
    logic         pixel_tlast;

    modport master (
        output chunk_tvalid, chunk_tdata, chunk_tlast, pixel_tready,
        input  chunk_tready, pixel_tvalid, pixel_tdata, pixel_tlast
    );

    modport slave (
        input  chunk_tvalid, chunk_tdata, chunk_tlast, pixel_tready,
        output chunk_tready, pixel_tvalid, pixel_tdata, pixel_tlast
    );
endinterface

// File: rtl/unstacker.sv
// Splits 128-bit chunks into 16 bytes, LSB first. PIPELINED=1 adds a second holding register.
// Optional macro UNSTACKER_STATS_EN adds a completed-chunk counter output chunks_done_out.
module unstacker #(
    parameter int PIPELINED = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    unstacker_if.slave stream
`ifdef UNSTACKER_STATS_EN
    ,
    output logic [31:0] chunks_done_out
`endif
);

    logic [127:0] r_curData;
    logic         r_curLast;
    logic         r_curValid;
    logic [3:0]   r_idx;
    logic         r_readyEn;

    logic         w_pixAcc;
    logic         w_curDone;
    logic         w_curFree;
    logic         w_chunkReady;
    logic         w_chunkAcc;
    logic         w_loadCur;
    logic [127:0] w_loadData;
    logic         w_loadLast;

    assign w_pixAcc   = r_curValid && stream.pixel_tready;
    assign w_curDone  = w_pixAcc && (r_idx == 4'd15);
    assign w_curFree  = !r_curValid || w_curDone;
    assign w_chunkAcc = stream.chunk_tvalid && w_chunkReady;

    generate
        if (PIPELINED != 0) begin : g_pipe
            logic [127:0] r_nxtData;
            logic         r_nxtLast;
            logic         r_nxtValid;

            // A chunk parks in nxt only while cur is still busy; nxt drains into cur as cur finishes.
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    r_nxtData  <= '0;
                    r_nxtLast  <= 1'b0;
                    r_nxtValid <= 1'b0;
                end else if (w_curFree && r_nxtValid) begin
                    r_nxtValid <= 1'b0;
                end else if (w_chunkAcc && !w_curFree) begin
                    r_nxtData  <= stream.chunk_tdata;
                    r_nxtLast  <= stream.chunk_tlast;
                    r_nxtValid <= 1'b1;
                end
            end

            assign w_chunkReady = r_readyEn && !r_nxtValid;
            assign w_loadCur    = w_curFree && (r_nxtValid || w_chunkAcc);
            assign w_loadData   = r_nxtValid ? r_nxtData : stream.chunk_tdata;
            assign w_loadLast   = r_nxtValid ? r_nxtLast : stream.chunk_tlast;
        end else begin : g_single
            assign w_chunkReady = r_readyEn &&
                                  (!r_curValid || ((r_idx == 4'd15) && stream.pixel_tready));
            assign w_loadCur    = w_chunkAcc && w_curFree;
            assign w_loadData   = stream.chunk_tdata;
            assign w_loadLast   = stream.chunk_tlast;
        end
    endgenerate

    // r_readyEn keeps chunk_tready low until the first edge after reset is released.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_curData  <= '0;
            r_curLast  <= 1'b0;
            r_curValid <= 1'b0;
            r_idx      <= 4'd0;
            r_readyEn  <= 1'b0;
        end else begin
            r_readyEn <= 1'b1;
            if (w_pixAcc) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_loadCur) begin
                r_curData  <= w_loadData;
                r_curLast  <= w_loadLast;
                r_curValid <= 1'b1;
            end else if (w_curDone) begin
                r_curValid <= 1'b0;
            end
        end
    end

`ifdef UNSTACKER_STATS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            chunks_done_out <= 32'd0;
        end else if (w_curDone) begin
            chunks_done_out <= chunks_done_out + 32'd1;
        end
    end
`endif

    assign stream.chunk_tready = w_chunkReady;
    assign stream.pixel_tvalid = r_curValid;
    assign stream.pixel_tdata  = r_curData[{r_idx, 3'b000} +: 8];
    assign stream.pixel_tlast  = r_curLast && (r_idx == 4'd15);

endmodule

// File: tb/tb_unstacker.sv
// Scoreboard bench for unstacker: a pipelined and a single-register instance run the same chunk stream.
// Define UNSTACKER_STATS_EN for both RTL and bench to also check chunks_done_out.
module tb_unstacker;

    typedef logic [128:0] chunkT;
    typedef logic [8:0]   byteT;

    logic clock;
    logic resetN;
    logic pReady;
    int   readyMode;
    int   checks;
    int   failures;

    logic         cValid[2];
    logic [127:0] cData[2];
    logic         cLast[2];
    logic         cReadyA[2];
    logic         pValidA[2];
    logic [7:0]   pDataA[2];
    logic         pLastA[2];
    int           byteCnt[2];

    chunkT feedQ[2][$];
    byteT  expQ[2][$];

`ifdef UNSTACKER_STATS_EN
    logic [31:0] chunksDone[2];
`endif

    unstacker_if busP();
    unstacker_if busS();

    assign busP.chunk_tvalid = cValid[0];
    assign busP.chunk_tdata  = cData[0];
    assign busP.chunk_tlast  = cLast[0];
    assign busP.pixel_tready = pReady;
    assign busS.chunk_tvalid = cValid[1];
    assign busS.chunk_tdata  = cData[1];
    assign busS.chunk_tlast  = cLast[1];
    assign busS.pixel_tready = pReady;

    assign cReadyA[0] = busP.chunk_tready;
    assign pValidA[0] = busP.pixel_tvalid;
    assign pDataA[0]  = busP.pixel_tdata;
    assign pLastA[0]  = busP.pixel_tlast;
    assign cReadyA[1] = busS.chunk_tready;
    assign pValidA[1] = busS.pixel_tvalid;
    assign pDataA[1]  = busS.pixel_tdata;
    assign pLastA[1]  = busS.pixel_tlast;

    unstacker #(.PIPELINED(1)) dutP (
        .clk_in (clock),
        .rst_in (resetN),
        .stream (busP)
`ifdef UNSTACKER_STATS_EN
        ,
        .chunks_done_out (chunksDone[0])
`endif
    );

    unstacker #(.PIPELINED(0)) dutS (
        .clk_in (clock),
        .rst_in (resetN),
        .stream (busS)
`ifdef UNSTACKER_STATS_EN
        ,
        .chunks_done_out (chunksDone[1])
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Issue the same chunk to both instances.
    task automatic applyStimulus(input logic [127:0] data, input logic last);
        feedQ[0].push_back({last, data});
        feedQ[1].push_back({last, data});
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((feedQ[0].size() + feedQ[1].size() + expQ[0].size() + expQ[1].size()) != 0 ||
               cValid[0] || cValid[1]) begin
            if (n >= budget) begin
                checks++;
                failures++;
                $display("[TB] FAIL drain_timeout actual=%0d bytes pending required=0",
                         expQ[0].size() + expQ[1].size());
                return;
            end
            @(negedge clock);
            #1;
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Downstream ready: 0 low, 1 high, 2 repeating 1,0,0,1, 3 random 50%.
    initial begin
        int patIdx;
        patIdx = 0;
        pReady = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (readyMode)
                0:       pReady = 1'b0;
                1:       pReady = 1'b1;
                2:       begin
                             pReady = (patIdx == 0) || (patIdx == 3);
                             patIdx = (patIdx + 1) % 4;
                         end
                default: pReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_harness
        // Driver: presents queued chunks and records their 16 expected bytes when issued.
        initial begin
            logic  fire;
            chunkT c;
            cValid[k] = 1'b0;
            cData[k]  = '0;
            cLast[k]  = 1'b0;
            forever begin
                @(negedge clock);
                fire = cValid[k] && cReadyA[k] && resetN;
                @(posedge clock);
                #1;
                if (fire || !resetN) cValid[k] = 1'b0;
                if (!cValid[k] && resetN && feedQ[k].size() > 0) begin
                    c = feedQ[k].pop_front();
                    cData[k]  = c[127:0];
                    cLast[k]  = c[128];
                    cValid[k] = 1'b1;
                    for (int b = 0; b < 16; b++) begin
                        expQ[k].push_back({c[128] && (b == 15), c[8*b +: 8]});
                    end
                end
            end
        end

        // Monitor: behavioural occupancy model (capacity 2 or 1 chunks) plus byte scoreboard.
        initial begin
            string       tag;
            int          held;
            int          pos;
            int unsigned doneCnt;
            logic        armed;
            logic        prevAcc;
            logic        prevStall;
            logic [7:0]  prevData;
            logic        prevLast;
            logic        expReady;
            byteT        e;
            tag = (k == 0) ? "pipe" : "single";
            held = 0; pos = 0; doneCnt = 0;
            armed = 1'b0; prevAcc = 1'b0; prevStall = 1'b0;
            prevData = '0; prevLast = 1'b0;
            byteCnt[k] = 0;
            forever begin
                @(negedge clock);
                if (!resetN) begin
                    expQ[k].delete();
                    held = 0; pos = 0; doneCnt = 0;
                    armed = 1'b0; prevAcc = 1'b0; prevStall = 1'b0;
                    continue;
                end
                if (!armed)      expReady = 1'b0;
                else if (k == 0) expReady = (held < 2);
                else             expReady = (held == 0) || ((pos == 15) && pReady);
                checkOutput({tag, ".chunk_tready"}, 32'(cReadyA[k]), 32'(expReady));
                checkOutput({tag, ".pixel_tvalid"}, 32'(pValidA[k]), 32'(held > 0));
                if (prevAcc && expQ[k].size() > 0)
                    checkOutput({tag, ".no_bubble"}, 32'(pValidA[k]), 32'(1));
                if (prevStall)
                    checkOutput({tag, ".stall_hold"}, {23'd0, pLastA[k], pDataA[k]},
                                {23'd0, prevLast, prevData});
`ifdef UNSTACKER_STATS_EN
                checkOutput({tag, ".chunks_done_out"}, chunksDone[k], doneCnt);
`endif
                if (pValidA[k] && pReady) begin
                    if (expQ[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL %s.extra_byte actual=0x%0h required=no byte", tag, pDataA[k]);
                    end else begin
                        e = expQ[k].pop_front();
                        checkOutput({tag, ".pixel_tdata"}, 32'(pDataA[k]), 32'(e[7:0]));
                        checkOutput({tag, ".pixel_tlast"}, 32'(pLastA[k]), 32'(e[8]));
                    end
                    byteCnt[k]++;
                    if (pos == 15) begin
                        held--;
                        doneCnt++;
                        pos = 0;
                    end else begin
                        pos++;
                    end
                end
                if (cValid[k] && cReadyA[k]) held++;
                prevAcc   = pValidA[k] && pReady;
                prevStall = pValidA[k] && !pReady;
                prevData  = pDataA[k];
                prevLast  = pLastA[k];
                armed     = 1'b1;
            end
        end
    end

    initial begin
        int base;
        int n;
        checks    = 0;
        failures  = 0;
        readyMode = 0;
        resetN    = 1'b1;
        #1 resetN = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset.pixel_tvalid", 32'(pValidA[k]), 32'(0));
            checkOutput("reset.pixel_tlast", 32'(pLastA[k]), 32'(0));
            checkOutput("reset.chunk_tready", 32'(cReadyA[k]), 32'(0));
        end
        repeat (2) @(posedge clock);
        #2 resetN = 1'b1;
        @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++)
            checkOutput("release.ready_before_edge", 32'(cReadyA[k]), 32'(0));
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++)
            checkOutput("release.ready_after_edge", 32'(cReadyA[k]), 32'(1));

        $display("[TB] single chunk, bytes 0x00..0x0F");
        readyMode = 1;
        applyStimulus(128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        waitDrain(200);

        $display("[TB] three chunks back-to-back, middle one with tlast");
        applyStimulus(rand128(), 1'b0);
        applyStimulus(rand128(), 1'b1);
        applyStimulus(rand128(), 1'b0);
        waitDrain(300);

        $display("[TB] downstream stalls, fixed 1,0,0,1 pattern");
        readyMode = 2;
        repeat (4) applyStimulus(rand128(), 1'($urandom_range(0, 1)));
        waitDrain(1000);

        $display("[TB] downstream stalls, random 50%%");
        readyMode = 3;
        repeat (8) applyStimulus(rand128(), 1'($urandom_range(0, 1)));
        waitDrain(2000);

        $display("[TB] reset mid-chunk after byte 7");
        readyMode = 1;
        repeat (2) @(posedge clock);
        #1;
        base = byteCnt[0];
        applyStimulus(rand128(), 1'b1);
        n = 0;
        while (byteCnt[0] < base + 8 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (byteCnt[0] < base + 8) begin
            checks++;
            failures++;
            $display("[TB] FAIL reset_test.byte7_timeout actual=%0d required=%0d", byteCnt[0] - base, 8);
        end
        @(posedge clock);
        #2 resetN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("midreset.pixel_tvalid", 32'(pValidA[k]), 32'(0));
            checkOutput("midreset.pixel_tlast", 32'(pLastA[k]), 32'(0));
            checkOutput("midreset.chunk_tready", 32'(cReadyA[k]), 32'(0));
`ifdef UNSTACKER_STATS_EN
            checkOutput("midreset.chunks_done_out", chunksDone[k], 32'd0);
`endif
        end
        @(posedge clock);
        #2 resetN = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++)
            checkOutput("postreset.pixel_tvalid", 32'(pValidA[k]), 32'(0));
        applyStimulus(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b0);
        waitDrain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unstacker.md
UNSTACKER -- requirements
Module: unstacker

Interface
REQ-001 The block SHALL have parameter PIPELINED, default 1, which selects a second 128-bit holding register for back-to-back chunk acceptance (1) or a single register (0).
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port chunk_tvalid, input, 1 bit: upstream chunk valid.
REQ-005 The block SHALL have port chunk_tready, output, 1 bit: block can accept a chunk.
REQ-006 The block SHALL have port chunk_tdata, input, 128 bits: 16 bytes, least-significant byte sent first.
REQ-007 The block SHALL have port chunk_tlast, input, 1 bit: end-of-frame marker for the chunk.
REQ-008 The block SHALL have port pixel_tvalid, output, 1 bit: byte valid.
REQ-009 The block SHALL have port pixel_tready, input, 1 bit: downstream accepts the byte.
REQ-010 The block SHALL have port pixel_tdata, output, 8 bits: current byte.
REQ-011 The block SHALL have port pixel_tlast, output, 1 bit: final byte of a chunk that arrived with chunk_tlast=1.

Function
REQ-012 Transfers SHALL occur only on cycles where valid && ready on the same interface.
REQ-013 Internal state SHALL be: current register cur_data[127:0], cur_last, cur_valid, byte index idx[3:0]; plus nxt_data, nxt_last, nxt_valid when PIPELINED=1.
REQ-014 pixel_tvalid SHALL equal cur_valid, pixel_tdata SHALL equal cur_data[8*idx+7 : 8*idx], and pixel_tlast SHALL equal cur_last && (idx==15), all driven from registers only.
REQ-015 On each pixel accept, idx SHALL increment; on the accept with idx==15, idx SHALL wrap to 0 and cur SHALL reload per REQ-017/018, else cur_valid SHALL clear.
REQ-016 Latency: a chunk accepted into an empty block at edge N SHALL present byte 0 with pixel_tvalid=1 immediately after edge N.
REQ-017 PIPELINED=1: chunk_tready SHALL equal !nxt_valid (registered, no path from pixel_tready).
REQ-018 PIPELINED=1: an accepted chunk SHALL load cur if cur is empty or its byte 15 is accepted the same cycle while nxt is empty; otherwise it SHALL load nxt; when cur finishes and nxt_valid=1, nxt SHALL move to cur and nxt_valid SHALL clear.
REQ-019 PIPELINED=1 with continuous valid/ready SHALL sustain one byte per cycle with no bubble between chunks.
REQ-020 PIPELINED=0: chunk_tready SHALL equal !cur_valid || (idx==15 && pixel_tready); an accepted chunk SHALL load cur directly.
REQ-021 A stall (pixel_tready=0) SHALL hold pixel_tdata, pixel_tlast, and idx unchanged.
REQ-022 chunk_tlast SHALL be attached only to byte 15 of its own chunk; bytes 0-14 SHALL carry pixel_tlast=0.
REQ-023 Chunk order SHALL be preserved; no chunk SHALL be dropped or duplicated.

Reset
REQ-024 While rst_in=0, the block SHALL immediately clear cur_valid, nxt_valid, idx, cur_last, and nxt_last, and SHALL drive chunk_tready=0, pixel_tvalid=0, and pixel_tlast=0; data registers SHALL be cleared to 0.
REQ-025 Reset asserted mid-chunk SHALL discard all buffered bytes, with no partial chunk emitted after release.
REQ-026 chunk_tready SHALL first rise on the first clock edge after rst_in returns to 1.

Configuration
REQ-027 With macro UNSTACKER_STATS_EN defined, the block SHALL add output port chunks_done_out (32 bits, reset 0), incremented on every byte-15 pixel accept and wrapping from 0xFFFFFFFF to 0.
REQ-028 Without UNSTACKER_STATS_EN, that port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL verify: one chunk 0x0F0E...0100 with tlast=0 and pixel_tready=1 -> bytes 0x00..0x0F on 16 consecutive cycles, pixel_tlast never 1.
REQ-030 The bench SHALL verify: PIPELINED=1, three chunks back-to-back, chunk_tvalid=1 continuous -> 48 consecutive bytes with no bubble; chunk_tready=0 while both registers are full.
REQ-031 The bench SHALL verify: chunk with tlast=1 -> pixel_tlast=1 only on byte 15 (0x0F), with the next chunk's bytes carrying tlast=0.
REQ-032 The bench SHALL verify: pixel_tready toggling 1,0,0,1 random at 50% -> byte stream identical to the unstalled case, and pixel_tdata stable during stalls.
REQ-033 The bench SHALL verify: rst_in driven low after byte 7 -> pixel_tvalid=0 without a clock edge; after release, a new chunk emits from its byte 0; chunks_done_out=0 when UNSTACKER_STATS_EN is defined.
REQ-034 The bench SHALL verify: PIPELINED=0, two chunks offered continuously -> second chunk accepted in the same cycle as byte 15 of the first, with no bubble.
